// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - MIPS-Lite ID stage: IF/ID register, decode, register file, load-use stall, ID/EX register
//
// Purpose: decodes the instruction held in IF/ID, reads the 32x32 register file
// (with write-back bypass), detects load-use hazards, raises a sticky halt and
// registers operands plus control into the ID/EX register.
// Ports:
//   clk, reset (sync, active-low)
//   instruction, pcPlus4        - fetched word and its PC+4
//   branchTaken                 - flush from EX
//   wbWriteEnable/Reg/Data      - write-back port
//   hazardDetected              - combinational stall to fetch
//   haltSignal                  - registered sticky halt to fetch
//   ex*                         - ID/EX register contents

module instruction_decode_stage #(
   parameter int ADDRESSWIDTH = 32,
   parameter int DATAWIDTH    = 32,
   parameter int REGCOUNT     = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             instruction,
   input  logic [ADDRESSWIDTH-1:0] pcPlus4,
   input  logic                    branchTaken,
   input  logic                    wbWriteEnable,
   input  logic [4:0]              wbWriteReg,
   input  logic [DATAWIDTH-1:0]    wbWriteData,
   output logic                    hazardDetected,
   output logic                    haltSignal,
   output logic                    exValid,
   output logic [5:0]              exOpcode,
   output logic [4:0]              exRs,
   output logic [4:0]              exRt,
   output logic [4:0]              exDest,
   output logic [DATAWIDTH-1:0]    exRsData,
   output logic [DATAWIDTH-1:0]    exRtData,
   output logic [DATAWIDTH-1:0]    exImm,
   output logic [ADDRESSWIDTH-1:0] exPcPlus4,
   output logic                    exRegWrite,
   output logic                    exMemRead,
   output logic                    exMemWrite,
   output logic                    exUsesImm,
   output logic                    exIsBranch
);

   localparam logic [5:0] OP_RMAX = 6'h0B;
   localparam logic [5:0] OP_LDW  = 6'h0C;
   localparam logic [5:0] OP_STW  = 6'h0D;
   localparam logic [5:0] OP_BZ   = 6'h0E;
   localparam logic [5:0] OP_BEQ  = 6'h0F;
   localparam logic [5:0] OP_JR   = 6'h10;
   localparam logic [5:0] OP_HALT = 6'h11;

   logic                    ifid_valid;
   logic [31:0]             ifid_instr;
   logic [ADDRESSWIDTH-1:0] ifid_pc4;
   logic [DATAWIDTH-1:0]    regs [REGCOUNT];

   logic [5:0]           op;
   logic [4:0]           rs, rt, rd;
   logic                 is_rtype, is_immop, is_stw, is_branch, is_halt, is_legal;
   logic                 uses_rs, uses_rt, issue;
   logic [4:0]           dest;
   logic [DATAWIDTH-1:0] rs_data, rt_data, imm_ext;

   always_comb begin
      op        = ifid_instr[31:26];
      rs        = ifid_instr[25:21];
      rt        = ifid_instr[20:16];
      rd        = ifid_instr[15:11];
      is_rtype  = (op <= OP_RMAX) && !op[0];
      is_immop  = ((op <= OP_RMAX) && op[0]) || (op == OP_LDW);
      is_stw    = (op == OP_STW);
      is_branch = (op == OP_BZ) || (op == OP_BEQ) || (op == OP_JR);
      is_halt   = (op == OP_HALT);
      is_legal  = (op <= OP_HALT);
      // Illegal opcodes read nothing so they can never cause a stall.
      uses_rs   = is_legal && !is_halt;
      uses_rt   = is_rtype || is_stw || (op == OP_BEQ);
      issue     = ifid_valid && is_legal && !is_halt;
      dest      = is_rtype ? rd : (is_immop ? rt : 5'd0);
      imm_ext   = {{(DATAWIDTH-16){ifid_instr[15]}}, ifid_instr[15:0]};
   end

   // Register reads; a write-back in the same cycle is forwarded. R0 is hardwired to 0.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs != 5'd0)
         rs_data = (wbWriteEnable && wbWriteReg == rs) ? wbWriteData : regs[rs];
      if (rt != 5'd0)
         rt_data = (wbWriteEnable && wbWriteReg == rt) ? wbWriteData : regs[rt];
   end

   always_comb begin
      hazardDetected = ifid_valid && exValid && exMemRead && (exDest != 5'd0) &&
                       ((uses_rs && exDest == rs) || (uses_rt && exDest == rt)) &&
                       !branchTaken && !haltSignal;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc4   <= '0;
         haltSignal <= 1'b0;
         for (int i = 0; i < REGCOUNT; i++)
            regs[i] <= '0;
         exValid    <= 1'b0;
         exOpcode   <= '0;
         exRs       <= '0;
         exRt       <= '0;
         exDest     <= '0;
         exRsData   <= '0;
         exRtData   <= '0;
         exImm      <= '0;
         exPcPlus4  <= '0;
         exRegWrite <= 1'b0;
         exMemRead  <= 1'b0;
         exMemWrite <= 1'b0;
         exUsesImm  <= 1'b0;
         exIsBranch <= 1'b0;
      end else begin
         if (wbWriteEnable && wbWriteReg != 5'd0)
            regs[wbWriteReg] <= wbWriteData;

         // Bubble by default; only a normal issue overrides it below.
         exValid    <= 1'b0;
         exOpcode   <= '0;
         exRs       <= '0;
         exRt       <= '0;
         exDest     <= '0;
         exRsData   <= '0;
         exRtData   <= '0;
         exImm      <= '0;
         exPcPlus4  <= '0;
         exRegWrite <= 1'b0;
         exMemRead  <= 1'b0;
         exMemWrite <= 1'b0;
         exUsesImm  <= 1'b0;
         exIsBranch <= 1'b0;

         if (branchTaken) begin
            ifid_valid <= 1'b0;
         end else if (haltSignal || hazardDetected) begin
            // IF/ID holds; ID/EX takes the bubble set above.
         end else begin
            ifid_valid <= 1'b1;
            ifid_instr <= instruction;
            ifid_pc4   <= pcPlus4;
            if (ifid_valid && is_halt)
               haltSignal <= 1'b1;
            if (issue) begin
               exValid    <= 1'b1;
               exOpcode   <= op;
               exRs       <= rs;
               exRt       <= rt;
               exDest     <= dest;
               exRsData   <= rs_data;
               exRtData   <= rt_data;
               exImm      <= imm_ext;
               exPcPlus4  <= ifid_pc4;
               exRegWrite <= is_rtype || is_immop;
               exMemRead  <= (op == OP_LDW);
               exMemWrite <= is_stw;
               exUsesImm  <= is_immop || is_stw;
               exIsBranch <= is_branch;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - directed self-checking bench for instruction_decode_stage

module tb_instruction_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] pcPlus4;
   logic        branchTaken;
   logic        wbWriteEnable;
   logic [4:0]  wbWriteReg;
   logic [31:0] wbWriteData;
   logic        hazardDetected, haltSignal, exValid;
   logic [5:0]  exOpcode;
   logic [4:0]  exRs, exRt, exDest;
   logic [31:0] exRsData, exRtData, exImm, exPcPlus4;
   logic        exRegWrite, exMemRead, exMemWrite, exUsesImm, exIsBranch;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] ILLEGAL = 32'hFC000000;

   instruction_decode_stage dut (
      .clk(clk), .reset(reset), .instruction(instruction), .pcPlus4(pcPlus4),
      .branchTaken(branchTaken), .wbWriteEnable(wbWriteEnable), .wbWriteReg(wbWriteReg),
      .wbWriteData(wbWriteData), .hazardDetected(hazardDetected), .haltSignal(haltSignal),
      .exValid(exValid), .exOpcode(exOpcode), .exRs(exRs), .exRt(exRt), .exDest(exDest),
      .exRsData(exRsData), .exRtData(exRtData), .exImm(exImm), .exPcPlus4(exPcPlus4),
      .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
      .exUsesImm(exUsesImm), .exIsBranch(exIsBranch)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; instruction = 32'h04020005; pcPlus4 = 32'h44; branchTaken = 1'b0;
      wbWriteEnable = 1'b0; wbWriteReg = 5'd0; wbWriteData = '0;
      tick(); tick();
      checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL reset_exValid: got %0h expected 0", exValid); end
      checks++; if (haltSignal !== 1'b0) begin errors++; $display("FAIL reset_halt: got %0h expected 0", haltSignal); end
      checks++; if (hazardDetected !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %0h expected 0", hazardDetected); end
      checks++; if (exPcPlus4 !== 32'h0 || exImm !== 32'h0 || exOpcode !== 6'h0) begin errors++; $display("FAIL reset_fields: got pc=%0h imm=%0h op=%0h expected 0", exPcPlus4, exImm, exOpcode); end
      reset = 1'b1;
   endtask

   task automatic test_decode();
      instruction = 32'h04020005; pcPlus4 = 32'h4;
      tick();
      instruction = ILLEGAL; pcPlus4 = 32'h8;
      checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL addi_latency: got exValid=%0h expected 0", exValid); end
      tick();
      checks++; if (exValid !== 1'b1 || exOpcode !== 6'h01) begin errors++; $display("FAIL addi_op: got valid=%0h op=%0h expected 1/01", exValid, exOpcode); end
      checks++; if (exDest !== 5'd2 || exImm !== 32'd5) begin errors++; $display("FAIL addi_dest_imm: got dest=%0d imm=%0h expected 2/5", exDest, exImm); end
      checks++; if (exRegWrite !== 1'b1 || exUsesImm !== 1'b1 || exMemRead !== 1'b0) begin errors++; $display("FAIL addi_ctl: got rw=%0h imm=%0h mr=%0h expected 1/1/0", exRegWrite, exUsesImm, exMemRead); end
      checks++; if (exPcPlus4 !== 32'h4) begin errors++; $display("FAIL addi_pc: got %0h expected 4", exPcPlus4); end
      instruction = 32'h0402FFFF;
      tick();
      instruction = 32'h34220004;
      tick();
      checks++; if (exImm !== 32'hFFFFFFFF || exDest !== 5'd2) begin errors++; $display("FAIL addi_signext: got imm=%0h dest=%0d expected ffffffff/2", exImm, exDest); end
      instruction = ILLEGAL;
      tick();
      checks++; if (exMemWrite !== 1'b1 || exUsesImm !== 1'b1 || exRegWrite !== 1'b0 || exDest !== 5'd0) begin errors++; $display("FAIL stw_ctl: got mw=%0h imm=%0h rw=%0h dest=%0d expected 1/1/0/0", exMemWrite, exUsesImm, exRegWrite, exDest); end
      tick();
      checks++; if (exValid !== 1'b0 || exRegWrite !== 1'b0) begin errors++; $display("FAIL illegal_bubble: got valid=%0h rw=%0h expected 0/0", exValid, exRegWrite); end
   endtask

   task automatic test_regfile();
      instruction = 32'h00602000;
      tick();
      instruction = ILLEGAL; wbWriteEnable = 1'b1; wbWriteReg = 5'd3; wbWriteData = 32'hDEADBEEF;
      tick();
      wbWriteEnable = 1'b0;
      checks++; if (exRsData !== 32'hDEADBEEF || exRs !== 5'd3) begin errors++; $display("FAIL wb_bypass: got rs=%0d data=%0h expected 3/deadbeef", exRs, exRsData); end
      checks++; if (exDest !== 5'd4 || exRegWrite !== 1'b1 || exUsesImm !== 1'b0) begin errors++; $display("FAIL add_ctl: got dest=%0d rw=%0h imm=%0h expected 4/1/0", exDest, exRegWrite, exUsesImm); end
      instruction = 32'h00003800; wbWriteEnable = 1'b1; wbWriteReg = 5'd0; wbWriteData = 32'd7;
      tick();
      instruction = ILLEGAL;
      tick();
      wbWriteEnable = 1'b0;
      checks++; if (exRsData !== 32'h0 || exRtData !== 32'h0) begin errors++; $display("FAIL r0_read: got rs=%0h rt=%0h expected 0/0", exRsData, exRtData); end
      instruction = 32'h00602000;
      tick();
      instruction = ILLEGAL;
      tick();
      checks++; if (exRsData !== 32'hDEADBEEF) begin errors++; $display("FAIL r3_stored: got %0h expected deadbeef", exRsData); end
   endtask

   task automatic test_hazard();
      instruction = 32'h30250000;
      tick();
      instruction = 32'h00A23000;
      tick();
      checks++; if (hazardDetected !== 1'b1) begin errors++; $display("FAIL ldw_use_rs: got %0h expected 1", hazardDetected); end
      checks++; if (exMemRead !== 1'b1 || exDest !== 5'd5 || exUsesImm !== 1'b1) begin errors++; $display("FAIL ldw_ctl: got mr=%0h dest=%0d imm=%0h expected 1/5/1", exMemRead, exDest, exUsesImm); end
      tick();
      checks++; if (exValid !== 1'b0 || hazardDetected !== 1'b0) begin errors++; $display("FAIL stall_bubble: got valid=%0h haz=%0h expected 0/0", exValid, hazardDetected); end
      instruction = ILLEGAL;
      tick();
      checks++; if (exValid !== 1'b1 || exRs !== 5'd5 || exRt !== 5'd2 || exDest !== 5'd6) begin errors++; $display("FAIL add_after_stall: got v=%0h rs=%0d rt=%0d dest=%0d expected 1/5/2/6", exValid, exRs, exRt, exDest); end
      tick();
      instruction = 32'h30250000;
      tick();
      instruction = 32'h04060001;
      tick();
      checks++; if (hazardDetected !== 1'b0) begin errors++; $display("FAIL ldw_no_use: got %0h expected 0", hazardDetected); end
      instruction = ILLEGAL;
      tick();
      checks++; if (exValid !== 1'b1 || exOpcode !== 6'h01 || exDest !== 5'd6) begin errors++; $display("FAIL no_bubble: got v=%0h op=%0h dest=%0d expected 1/01/6", exValid, exOpcode, exDest); end
      instruction = 32'h30250000;
      tick();
      instruction = 32'h00453000;
      tick();
      checks++; if (hazardDetected !== 1'b1) begin errors++; $display("FAIL ldw_use_rt: got %0h expected 1", hazardDetected); end
      instruction = ILLEGAL;
      tick(); tick(); tick();
   endtask

   task automatic test_branch();
      instruction = 32'h30250000;
      tick();
      instruction = 32'h00A23000;
      tick();
      branchTaken = 1'b1; instruction = ILLEGAL;
      #1;
      checks++; if (hazardDetected !== 1'b0) begin errors++; $display("FAIL hazard_during_flush: got %0h expected 0", hazardDetected); end
      tick();
      branchTaken = 1'b0;
      checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %0h expected 0", exValid); end
      tick();
      checks++; if (exValid !== 1'b0) begin errors++; $display("FAIL wrong_path: got exValid=%0h op=%0h expected 0", exValid, exOpcode); end
      instruction = 32'h3C220008;
      tick();
      instruction = ILLEGAL;
      tick();
      checks++; if (exIsBranch !== 1'b1 || exRegWrite !== 1'b0 || exDest !== 5'd0 || exRt !== 5'd2 || exImm !== 32'd8) begin errors++; $display("FAIL beq_decode: got br=%0h rw=%0h dest=%0d rt=%0d imm=%0h expected 1/0/0/2/8", exIsBranch, exRegWrite, exDest, exRt, exImm); end
   endtask

   task automatic test_halt();
      instruction = 32'h44000000;
      tick();
      checks++; if (haltSignal !== 1'b0) begin errors++; $display("FAIL halt_early: got %0h expected 0", haltSignal); end
      instruction = 32'h00003800;
      tick();
      checks++; if (haltSignal !== 1'b1 || exValid !== 1'b0) begin errors++; $display("FAIL halt_rise: got halt=%0h valid=%0h expected 1/0", haltSignal, exValid); end
      tick(); tick(); tick();
      checks++; if (haltSignal !== 1'b1 || exValid !== 1'b0) begin errors++; $display("FAIL halt_sticky: got halt=%0h valid=%0h expected 1/0", haltSignal, exValid); end
      reset = 1'b0;
      tick();
      checks++; if (haltSignal !== 1'b0 || exValid !== 1'b0) begin errors++; $display("FAIL halt_reset: got halt=%0h valid=%0h expected 0/0", haltSignal, exValid); end
      reset = 1'b1; instruction = 32'h00602000; pcPlus4 = 32'h20;
      tick();
      instruction = ILLEGAL;
      tick();
      checks++; if (exValid !== 1'b1 || exRsData !== 32'h0 || exPcPlus4 !== 32'h20) begin errors++; $display("FAIL regs_cleared: got v=%0h data=%0h pc=%0h expected 1/0/20", exValid, exRsData, exPcPlus4); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_regfile();
      test_hazard();
      test_branch();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
Pipeline stage directly downstream of instruction fetch in the MIPS-Lite 5-stage pipeline. It holds the IF/ID register, decodes the instruction and reads the 32x32 register file, which has a write-back bypass. It detects load-use hazards and drives the stall (hazardDetected) back to fetch. It registers operands and control into the ID/EX register consumed by execute. It also raises the sticky haltSignal used by fetch.

Parameters:
ADDRESSWIDTH, 32, width of PC and pcPlus4
DATAWIDTH, 32, register and immediate width
REGCOUNT, 32, number of architectural registers (index width 5)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
instruction  input  32  fetched instruction word from fetch
pcPlus4  input  ADDRESSWIDTH  fetch PC+4 paired with instruction
branchTaken  input  1  branch/jump resolved taken in EX; flush
wbWriteEnable  input  1  write-back register write strobe
wbWriteReg  input  5  write-back destination index
wbWriteData  input  DATAWIDTH  write-back data
hazardDetected  output  1  combinational load-use stall to fetch
haltSignal  output  1  registered, sticky halt to fetch
exValid  output  1  ID/EX slot holds a real instruction
exOpcode  output  6  ID/EX opcode
exRs, exRt, exDest  output  5 each  source/destination indices
exRsData, exRtData  output  DATAWIDTH  register operands
exImm  output  DATAWIDTH  sign-extended imm[15:0]
exPcPlus4  output  ADDRESSWIDTH  PC+4 of the ID/EX instruction
exRegWrite, exMemRead, exMemWrite, exUsesImm, exIsBranch  output  1 each  control bits

Behaviour:
- Encoding: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Opcodes 0x00–0x11 are ADD, ADDI, SUB, SUBI, MUL, MULI, OR, ORI, AND, ANDI, XOR, XORI, LDW, STW, BZ, BEQ, JR, HALT. Opcodes 0x12–0x3F are illegal.
- R-type ops use even opcodes 0x00–0x0A: exDest = rd, exRegWrite = 1, exUsesImm = 0.
- Immediate arithmetic uses odd opcodes 0x01–0x0B; LDW also uses this form: exDest = rt, exRegWrite = 1, exUsesImm = 1. LDW additionally sets exMemRead.
- STW: exMemWrite = 1, exUsesImm = 1, no register write.
- BZ, BEQ, JR: exIsBranch = 1, no register write.
- For every op with no register write, exDest = 0.
- Source usage: rs is read by all ops except HALT. rt is read by R-type ops, STW and BEQ.
- Reset (reset == 0 at an edge):
  - IF/ID register is invalid and holds zero.
  - All ex* outputs are 0.
  - haltSignal is 0.
  - All registers are 0.
- Latency: an instruction presented at edge N is in IF/ID after edge N and appears on the ex* outputs after edge N+1.
- Register file:
  - R0 reads 0; writes to R0 are ignored.
  - Writes occur at the edge when wbWriteEnable = 1.
  - Same-cycle bypass: if wbWriteEnable = 1, wbWriteReg != 0 and wbWriteReg equals the read index, the read returns wbWriteData.
- hazardDetected = IF/ID valid & exValid & exMemRead & exDest != 0 & (exDest == rs of the ID instruction, or exDest == rt when rt is a used source).
  - Stays 0 while branchTaken = 1 or haltSignal = 1.
- Per-edge priority (highest first):
  1. Reset.
  2. branchTaken: IF/ID invalidated and ID/EX loaded with a bubble. A HALT in IF/ID is discarded.
  3. haltSignal already 1: IF/ID is not updated; ID/EX is loaded with a bubble every cycle.
  4. hazardDetected: IF/ID holds its contents; ID/EX is loaded with a bubble.
  5. Normal operation: IF/ID captures instruction and pcPlus4 with valid = 1; ID/EX captures the decode.
- Bubble: exValid = 0 and all control bits = 0; data fields are don't-care but driven to 0.
- HALT decoded from a valid IF/ID entry (not flushed): ID/EX gets a bubble and haltSignal = 1 from the next edge until reset.
- Illegal opcode: treated as a bubble. No stall, no halt, no register write.
- Reset asserted mid-stall or mid-halt: everything returns to reset values at that edge.

Test Plan:
- Reset, then present ADDI r2,r0,5 (0x04020005) with pcPlus4 = 4 -> after 2 edges: exValid = 1, exOpcode = 0x01, exDest = 2, exImm = 5, exRegWrite = 1, exUsesImm = 1, exPcPlus4 = 4.
- WB writes r3 = 0xDEADBEEF in the same cycle that ADD r4,r3,r0 is in IF/ID -> exRsData = 0xDEADBEEF. A WB write to r0 with data 7 -> later reads of r0 return 0.
- LDW r5,0(r1), then ADD r6,r5,r2 -> hazardDetected = 1 for exactly one cycle; IF/ID holds; one bubble (exValid = 0). ADD then issues with exRs = 5.
- LDW r5, then ADDI r6,r0,1 (no use of r5) -> hazardDetected stays 0; no bubble.
- BEQ in ID/EX with branchTaken = 1 while ADD sits in IF/ID -> the next ID/EX is a bubble, the IF/ID entry is invalidated, and the wrong-path instruction never reaches ID/EX.
- HALT (0x44000000) followed by ADD -> haltSignal rises one edge after HALT is decoded and stays 1; exValid = 0 thereafter. Asserting reset low clears haltSignal.
